// File: rtl/trans_block_packer.sv
// Buffers validated 128-bit transactions and serialises them as 32-bit words on
// a valid/ready stream. A 2-word block summary (count, amount) is inserted whenever a block closes.
module trans_block_packer #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SUM_TAG    = 8'hB5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_i,
  input  logic         valid_i,
  input  logic         flush_i,
  output logic [31:0]  word_o,
  output logic         word_valid_o,
  input  logic         word_ready_i,
  output logic         overflow_o,
  output logic [15:0]  blk_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SUM0, SUM1, TX0, TX1, TX2, TX3} state_t;

  // Output stream: a word transfers on a rising edge where word_valid_o and
  // word_ready_i are both high. Valid depends only on registered state, and
  // word_o/word_valid_o hold their values while valid is high and ready is low.

  state_t        state_q, state_d;
  logic [127:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [127:0]  frame_q, frame_d;
  logic [15:0]   tx_cnt_q, tx_cnt_d;
  logic [31:0]   amt_sum_q, amt_sum_d;
  logic [15:0]   blk_count_q, blk_count_d;
  logic          flush_pend_q, flush_clr;
  logic          overflow_q;

  logic          full, empty, push, pop, hs;
  logic [127:0]  head;
  logic [32:0]   sum_ext;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = valid_i & ~full;
  assign head    = mem_q[rd_ptr_q];
  assign hs      = word_valid_o & word_ready_i;
  assign sum_ext = {1'b0, amt_sum_q} + {11'b0, head[31:10]};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      frame_q      <= '0;
      tx_cnt_q     <= '0;
      amt_sum_q    <= '0;
      blk_count_q  <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      state_q      <= state_d;
      frame_q      <= frame_d;
      tx_cnt_q     <= tx_cnt_d;
      amt_sum_q    <= amt_sum_d;
      blk_count_q  <= blk_count_d;
      // A new flush request in the same cycle as a clear stays pending.
      flush_pend_q <= (flush_pend_q & ~flush_clr) | flush_i;
      if (valid_i & full) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    frame_d     = frame_q;
    tx_cnt_d    = tx_cnt_q;
    amt_sum_d   = amt_sum_q;
    blk_count_d = blk_count_q;
    flush_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          // A block_start head closes the open block before it is framed.
          if (head[9] && (tx_cnt_q != '0)) begin
            state_d = SUM0;
          end else begin
            pop       = 1'b1;
            frame_d   = head;
            tx_cnt_d  = (tx_cnt_q == 16'hFFFF) ? tx_cnt_q : tx_cnt_q + 16'd1;
            amt_sum_d = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
            state_d   = TX0;
          end
        end else if (flush_pend_q) begin
          if (tx_cnt_q != '0) state_d = SUM0;
          else                flush_clr = 1'b1;
        end
      end
      SUM0: if (hs) state_d = SUM1;
      SUM1: begin
        if (hs) begin
          tx_cnt_d    = '0;
          amt_sum_d   = '0;
          blk_count_d = blk_count_q + 16'd1;
          flush_clr   = 1'b1;
          state_d     = IDLE;
        end
      end
      TX0: if (hs) state_d = TX1;
      TX1: if (hs) state_d = TX2;
      TX2: if (hs) state_d = TX3;
      TX3: if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_o = '0;
    case (state_q)
      SUM0:    word_o = {SUM_TAG, 8'h00, tx_cnt_q};
      SUM1:    word_o = amt_sum_q;
      TX0:     word_o = frame_q[127:96];
      TX1:     word_o = frame_q[95:64];
      TX2:     word_o = frame_q[63:32];
      TX3:     word_o = frame_q[31:0];
      default: word_o = '0;
    endcase
  end

  assign word_valid_o = (state_q != IDLE);
  assign overflow_o   = overflow_q;
  assign blk_count_o  = blk_count_q;

endmodule

// File: tb/tb_trans_block_packer.sv
// Bench for trans_block_packer: directed table and corner sequences plus a
// randomized run scored against a word-stream reference model.
module tb_trans_block_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] data_i;
  logic         valid_i;
  logic         flush_i;
  logic [31:0]  word_o;
  logic         word_valid_o;
  logic         word_ready_i;
  logic         overflow_o;
  logic [15:0]  blk_count_o;

  trans_block_packer #(.FIFO_DEPTH(16), .SUM_TAG(8'hB5)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .flush_i(flush_i),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .overflow_o(overflow_o), .blk_count_o(blk_count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int rdy_mode = 0;   // 0 high, 1 low, 2 random, 3 driven by the sequence

  logic [15:0] m_cnt;
  logic [31:0] m_sum;
  logic [15:0] m_blk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_cnt = '0; m_sum = '0; m_blk = '0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rdy_mode == 0)      word_ready_i = 1'b1;
      else if (rdy_mode == 1) word_ready_i = 1'b0;
      else if (rdy_mode == 2) word_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_tx(input logic [127:0] d);
    data_i = d; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    idle(3);
  endtask

  task automatic throttle();
    int t = 0;
    while (exp_q.size() >= 40 && t < 3000) begin @(posedge clk); #1; t++; end
    if (exp_q.size() >= 40) begin
      n_vec++; n_err++;
      $display("FAIL throttle_timeout: %0d words outstanding, expected < 40", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [127:0] mk_tx(input logic bs, input logic [21:0] amt);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[31:10] = amt;
    d[9] = bs;
    return d;
  endfunction

  // ---------------- reference model ----------------
  // Expected output stream: summaries close blocks, each tx yields 4 words.
  task automatic model_close();
    exp_q.push_back({8'hB5, 8'h00, m_cnt});
    exp_q.push_back(m_sum);
    m_cnt = '0; m_sum = '0; m_blk = m_blk + 16'd1;
  endtask

  task automatic model_tx(input logic [127:0] d);
    longint s;
    if (d[9] && m_cnt != 0) model_close();
    exp_q.push_back(d[127:96]); exp_q.push_back(d[95:64]);
    exp_q.push_back(d[63:32]);  exp_q.push_back(d[31:0]);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    s = longint'(m_sum) + longint'(d[31:10]);
    m_sum = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endtask

  task automatic model_flush();
    if (m_cnt != 0) model_close();
  endtask

  // ---------------- scoreboard ----------------
  logic        stall_prev = 1'b0;
  logic [31:0] prev_word;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("hold_valid", {31'b0, word_valid_o}, 32'd1);
        check("hold_word", word_o, prev_word);
      end
      if (word_valid_o && word_ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_word: got %h expected no word", word_o);
        end else begin
          check("word", word_o, exp_q.pop_front());
        end
      end
      stall_prev = word_valid_o && !word_ready_i;
      prev_word  = word_o;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic        is_flush;
    logic        bs;
    logic [21:0] amt;
    logic        has_sum;
    logic [31:0] sum0;
    logic [31:0] sum1;
    logic [15:0] blk;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    word_ready_i = 1'b1; data_i = '0;
    tbl[0] = '{1'b0, 1'b0, 22'd7, 1'b0, 32'h0,         32'h0,         16'd0};
    tbl[1] = '{1'b0, 1'b0, 22'd9, 1'b0, 32'h0,         32'h0,         16'd0};
    tbl[2] = '{1'b0, 1'b1, 22'd1, 1'b1, 32'hB500_0003, 32'h0000_0015, 16'd1};
    tbl[3] = '{1'b0, 1'b0, 22'd2, 1'b0, 32'h0,         32'h0,         16'd1};
    tbl[4] = '{1'b1, 1'b0, 22'd0, 1'b1, 32'hB500_0002, 32'h0000_0003, 16'd2};
    tbl[5] = '{1'b1, 1'b0, 22'd0, 1'b0, 32'h0,         32'h0,         16'd2};

    do_reset();
    @(negedge clk);
    check("rst_word", word_o, 32'h0);
    check("rst_valid", {31'b0, word_valid_o}, 32'd0);
    check("rst_overflow", {31'b0, overflow_o}, 32'd0);
    check("rst_blk", {16'b0, blk_count_o}, 32'd0);
    @(posedge clk); #1;

    // First tx opens a block: no summary, first word two cycles after valid_i.
    d = mk_tx(1'b1, 22'd5);
    exp_q.push_back(d[127:96]); exp_q.push_back(d[95:64]);
    exp_q.push_back(d[63:32]);  exp_q.push_back(d[31:0]);
    send_tx(d);
    @(negedge clk);
    check("lat_n1_valid", {31'b0, word_valid_o}, 32'd0);
    @(negedge clk);
    check("lat_n2_valid", {31'b0, word_valid_o}, 32'd1);
    check("lat_n2_word", word_o, d[127:96]);
    drain();

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].has_sum) begin
        exp_q.push_back(tbl[i].sum0);
        exp_q.push_back(tbl[i].sum1);
      end
      if (tbl[i].is_flush) begin
        pulse_flush();
      end else begin
        d = mk_tx(tbl[i].bs, tbl[i].amt);
        exp_q.push_back(d[127:96]); exp_q.push_back(d[95:64]);
        exp_q.push_back(d[63:32]);  exp_q.push_back(d[31:0]);
        send_tx(d);
      end
      drain();
      check($sformatf("tbl%0d_blk", i), {16'b0, blk_count_o}, {16'b0, tbl[i].blk});
    end
    m_cnt = '0; m_sum = '0; m_blk = 16'd2;

    // Stall 10 cycles with TX1 on the bus.
    rdy_mode = 3; word_ready_i = 1'b0;
    d = mk_tx(1'b0, 22'd4);
    model_tx(d);
    send_tx(d);
    idle(2);
    word_ready_i = 1'b1;
    idle(1);
    word_ready_i = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("tx1_hold_word", word_o, d[95:64]);
      check("tx1_hold_valid", {31'b0, word_valid_o}, 32'd1);
      @(posedge clk); #1;
    end
    rdy_mode = 0;
    drain();

    // Overflow: one tx parked in the frame, 16 buffered, 17th dropped.
    do_reset();
    rdy_mode = 3; word_ready_i = 1'b0;
    d = mk_tx(1'b0, 22'd1);
    model_tx(d);
    send_tx(d);
    idle(2);
    for (int i = 0; i < 17; i++) begin
      d = mk_tx(1'b0, 22'($urandom_range(0, 1000)));
      if (i < 16) model_tx(d);
      send_tx(d);
    end
    @(negedge clk);
    check("ovf_set", {31'b0, overflow_o}, 32'd1);
    @(posedge clk); #1;
    rdy_mode = 0;
    drain();
    check("ovf_sticky", {31'b0, overflow_o}, 32'd1);

    // Reset during TX2 abandons the frame and clears the counters.
    do_reset();
    check("ovf_cleared", {31'b0, overflow_o}, 32'd0);
    rdy_mode = 3; word_ready_i = 1'b0;
    d = mk_tx(1'b0, 22'd6);
    model_tx(d);
    send_tx(d);
    idle(2);
    word_ready_i = 1'b1;
    idle(2);
    word_ready_i = 1'b0;
    @(negedge clk);
    check("tx2_word", word_o, d[63:32]);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_cnt = '0; m_sum = '0; m_blk = '0;
    @(negedge clk);
    check("rst6_valid", {31'b0, word_valid_o}, 32'd0);
    check("rst6_word", word_o, 32'h0);
    check("rst6_blk", {16'b0, blk_count_o}, 32'd0);
    @(posedge clk); #1;
    rdy_mode = 0;
    d = mk_tx(1'b1, 22'd11);
    model_tx(d);
    send_tx(d);
    drain();
    model_flush();
    pulse_flush();
    drain();
    check("rst6_blk_after", {16'b0, blk_count_o}, {16'b0, m_blk});

    // Amount saturation across a long block.
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 1100; i++) begin
      d = mk_tx(1'b0, 22'($urandom_range(22'h3F0000, 22'h3FFFFF)));
      throttle();
      model_tx(d);
      send_tx(d);
    end
    drain();
    check("sat_model_sum", m_sum, 32'hFFFF_FFFF);
    model_flush();
    pulse_flush();
    drain();
    check("sat_blk", {16'b0, blk_count_o}, {16'b0, m_blk});

    // Randomized traffic with random backpressure and flushes.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        drain();
        model_flush();
        pulse_flush();
        drain();
        check("rand_blk", {16'b0, blk_count_o}, {16'b0, m_blk});
      end else begin
        d = mk_tx($urandom_range(0, 5) == 0, 22'($urandom));
        throttle();
        model_tx(d);
        send_tx(d);
        idle($urandom_range(0, 3));
      end
    end
    drain();
    model_flush();
    pulse_flush();
    drain();
    check("final_blk", {16'b0, blk_count_o}, {16'b0, m_blk});
    check("final_overflow", {31'b0, overflow_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
